// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: one requester at a time owns the shared resource
// port until its last beat or until MAX_BURST beats have transferred.
module rr_burst_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [NREQ-1:0]           gnt,
  output logic [$clog2(NREQ)-1:0]   gnt_id,
  output logic                      busy,
  output logic                      forced_release
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [BW-1:0]   beat_cnt;
  logic [IW-1:0]   win;
  logic [IW-1:0]   cand;
  logic            found;
  logic            xfer;
  logic            at_limit;
  logic            is_last;

  assign res_valid = busy & req_valid[gnt_id];
  assign req_ready = gnt & {NREQ{res_ready}};
  assign xfer      = res_valid & res_ready;
  assign at_limit  = (beat_cnt == BW'(MAX_BURST - 1));
  assign is_last   = req_last[gnt_id];

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      gnt            <= '0;
      gnt_id         <= '0;
      busy           <= 1'b0;
      forced_release <= 1'b0;
      ptr            <= '0;
      beat_cnt       <= '0;
    end else begin
      forced_release <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state    <= BUSY;
            busy     <= 1'b1;
            gnt      <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            gnt_id   <= win;
            beat_cnt <= '0;
          end
        end
        BUSY: begin
          if (xfer) begin
            if (is_last || at_limit) begin
              state          <= IDLE;
              busy           <= 1'b0;
              gnt            <= '0;
              forced_release <= ~is_last;
              ptr            <= (gnt_id == IW'(NREQ - 1)) ? '0 : IW'(gnt_id + 1'b1);
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: directed handoff scenarios plus random traffic,
// every cycle compared against a transaction-level ownership model.
module tb_rr_burst_arbiter;

  localparam int N    = 4;
  localparam int MAXB = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req_valid, req_last, req_ready, gnt;
  logic         res_valid, res_ready, busy, forced_release;
  logic [1:0]   gnt_id;

  rr_burst_arbiter #(.NREQ(N), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .forced_release(forced_release)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the port, how many beats it has moved, where
  // the search starts next, and the last-granted id.
  int m_owner = -1, m_cnt = 0, m_ptr = 0, m_id = 0;
  bit m_forced = 0;

  // Scenario observations taken from the DUT.
  int           starts[$];
  int           xfers, forced_n, stall_n;
  logic [N-1:0] rdy_seen;
  bit           seen_busy = 0;
  bit           armed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic [N-1:0] v, input logic [N-1:0] l,
                            input logic r, input logic rst);
    if (rst) begin
      m_owner = -1; m_cnt = 0; m_ptr = 0; m_id = 0; m_forced = 0;
    end else begin
      m_forced = 0;
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && v[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            m_id    = m_owner;
            m_cnt   = 0;
          end
        end
      end else if (v[m_owner] && r) begin
        m_cnt++;
        if (l[m_owner] || m_cnt == MAXB) begin
          m_forced = !l[m_owner];
          m_ptr    = (m_owner + 1) % N;
          m_owner  = -1;
        end
      end
    end
  endtask

  task automatic compare_all(input logic [N-1:0] v, input logic r);
    logic [31:0] e_gnt;
    e_gnt = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    check("gnt",       32'(gnt),            e_gnt);
    check("busy",      32'(busy),           32'(m_owner >= 0));
    check("gnt_id",    32'(gnt_id),         32'(m_id));
    check("forced",    32'(forced_release), 32'(m_forced));
    check("res_valid", 32'(res_valid),      32'((m_owner >= 0) && v[m_id]));
    check("req_ready", 32'(req_ready),      r ? e_gnt : 32'd0);
  endtask

  task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] l,
                     input logic r, input logic rst = 1'b0);
    @(negedge clk);
    reset = rst; req_valid = v; req_last = l; res_ready = r;
    #1;
    if (armed) compare_all(v, r);
    if (busy && !seen_busy) starts.push_back(int'(gnt_id));
    seen_busy = busy;
    if (res_valid && res_ready && !rst) xfers++;
    if (forced_release) forced_n++;
    if (gnt == 4'b1000 && !res_valid) stall_n++;
    rdy_seen |= req_ready;
    @(posedge clk);
    model_step(v, l, r, rst);
  endtask

  task automatic clr();
    starts.delete();
    xfers = 0; forced_n = 0; stall_n = 0; rdy_seen = '0;
  endtask

  task automatic check_starts(input string tag, input int exp[$]);
    check({tag, "_ngrants"}, 32'(starts.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < starts.size(); i++)
      check({tag, "_grant"}, 32'(starts[i]), 32'(exp[i]));
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_last = '0; res_ready = 1'b0;
    cyc('0, '0, 1'b0, 1'b1);
    armed = 1;

    // All requesters valid, 2-beat bursts: grants rotate with one idle cycle.
    clr();
    cyc(4'b1111, '0, 1'b1);
    for (int g = 0; g < 5; g++) begin
      cyc(4'b1111, 4'b0000, 1'b1);
      cyc(4'b1111, 4'b1111, 1'b1);
      cyc(4'b1111, 4'b0000, 1'b1);
    end
    check_starts("rot", '{0, 1, 2, 3, 0});
    check("rot_xfers", 32'(xfers), 32'd10);
    check("rot_forced", 32'(forced_n), 32'd0);

    // Requester 2 alone, res_ready toggling.
    cyc('0, '0, 1'b0, 1'b1);
    clr();
    cyc(4'b0100, '0, 1'b1);
    cyc(4'b0100, 4'b0000, 1'b1);
    cyc(4'b0100, 4'b0000, 1'b0);
    cyc(4'b0100, 4'b0000, 1'b1);
    cyc(4'b0100, 4'b0000, 1'b0);
    cyc(4'b0100, 4'b0100, 1'b1);
    cyc(4'b0000, 4'b0000, 1'b1);
    check("tog_xfers", 32'(xfers), 32'd3);
    check("tog_ready", 32'(rdy_seen), 32'h4);
    check_starts("tog", '{2});

    // Requester 1 never signals last: forced release after MAX_BURST beats.
    cyc('0, '0, 1'b0, 1'b1);
    clr();
    cyc(4'b0010, '0, 1'b1);
    for (int b = 0; b < MAXB; b++) cyc(4'b1011, 4'b0000, 1'b1);
    cyc(4'b1011, 4'b0000, 1'b1);
    check("lim_xfers", 32'(xfers), 32'd8);
    check("lim_forced", 32'(forced_n), 32'd1);
    check_starts("lim", '{1});

    // Requester 3 wins over 0; its 8th beat carries last, so no forced pulse.
    clr();
    for (int b = 0; b < MAXB - 1; b++) cyc(4'b1000, 4'b0000, 1'b1);
    cyc(4'b1000, 4'b1000, 1'b1);
    cyc(4'b0000, 4'b0000, 1'b1);
    check_starts("last8", '{3});
    check("last8_xfers", 32'(xfers), 32'd8);
    check("last8_forced", 32'(forced_n), 32'd0);

    // Granted requester 3 stalls for 5 cycles while requester 0 waits.
    cyc('0, '0, 1'b0, 1'b1);
    clr();
    cyc(4'b1000, '0, 1'b1);
    cyc(4'b1001, 4'b0000, 1'b1);
    for (int s = 0; s < 5; s++) cyc(4'b0001, 4'b0000, 1'b1);
    cyc(4'b1001, 4'b1000, 1'b1);
    cyc(4'b0001, 4'b0000, 1'b1);
    cyc(4'b0001, 4'b0001, 1'b1);
    check("stall_cycles", 32'(stall_n), 32'd5);
    check_starts("stall", '{3, 0});
    check("stall_xfers", 32'(xfers), 32'd3);

    // Reset mid-burst on requester 2 restores priority to the low end.
    cyc('0, '0, 1'b0, 1'b1);
    clr();
    cyc(4'b0010, '0, 1'b1);
    cyc(4'b0010, 4'b0010, 1'b1);
    cyc(4'b0110, 4'b0000, 1'b1);
    cyc(4'b0110, 4'b0000, 1'b1);
    check("pre_rst_gnt", 32'(gnt), 32'h4);
    cyc(4'b0110, 4'b0000, 1'b1, 1'b1);
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    cyc(4'b0110, 4'b0000, 1'b1);
    #1;
    check("post_rst_id", 32'(gnt_id), 32'h1);
    check("post_rst_gnt", 32'(gnt), 32'h2);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] v, l;
      v = N'($urandom);
      l = N'($urandom) & N'($urandom);
      cyc(v, l, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    end
    cyc('0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_burst_arbiter.md
# rr_burst_arbiter

Round-robin burst arbiter that shares one downstream resource port among NREQ requesters. It grants a single requester at a time and holds the grant for a whole burst, releasing on the requester's last beat or after MAX_BURST beats, whichever comes first. It sits between requester-side valid/ready channels and the shared resource's single valid/ready input, and drives the resource's source-select.

## Interface
- NREQ, 4: number of requesters; legal range 2..16.
- MAX_BURST, 8: maximum beats per grant before forced release; legal range 2..256.
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester beat valid.
- req_last  input  NREQ  per-requester last-beat flag; sampled only on a transferring beat.
- req_ready  output  NREQ  per-requester ready; combinational, gnt[i] & res_ready.
- res_valid  output  1  valid to resource; combinational, busy & req_valid[gnt_id].
- res_ready  input  1  resource ready.
- gnt  output  NREQ  registered one-hot grant; all-zero when idle.
- gnt_id  output  $clog2(NREQ)  registered index of the granted requester; drives the resource mux.
- busy  output  1  registered; high while a grant is held.
- forced_release  output  1  registered one-cycle pulse when a grant ends by the MAX_BURST limit rather than by req_last.

## Operation
- Beat transfer: a cycle with busy & req_valid[gnt_id] & res_ready.
- State machine, two states:
  - IDLE: busy=0, gnt=0.
    - If any req_valid bit is set, the winner is the first set bit searched from ptr upward, wrapping from NREQ-1 to 0.
    - Go to BUSY; gnt=onehot(winner), gnt_id=winner, beat_cnt=0.
  - BUSY: grant is held. No preemption.
    - If the granted requester drops req_valid, the grant stalls and is held indefinitely.
    - On each transfer, beat_cnt increments.
    - Release on a transfer with req_last[gnt_id]=1 (normal), or on a transfer with beat_cnt==MAX_BURST-1 (forced).
    - On release: go to IDLE, gnt=0, busy=0, ptr=(gnt_id+1) mod NREQ.
    - forced_release=1 for one cycle only if the limit beat does not also carry req_last.
- beat_cnt width: $clog2(MAX_BURST). It counts 0..MAX_BURST-1 and never wraps while busy.
- ptr width: $clog2(NREQ). The mod-NREQ wrap is explicit, so non-power-of-two NREQ never produces an out-of-range ptr.
- req_valid on non-granted requesters while BUSY is ignored; those requesters see req_ready=0.
- gnt_id holds its last value in IDLE. The resource must qualify it with busy/res_valid.
- Reset: gnt=0, gnt_id=0, busy=0, forced_release=0, ptr=0, beat_cnt=0, state IDLE.
  - Reset mid-burst abandons the burst; no transfer occurs in the reset cycle.
  - After reset, requester 0 has top priority.

## Timing
- Arbitration latency: a request seen in IDLE at edge t gives gnt/busy high after edge t.
  - The first transfer can occur in that same cycle, i.e. one cycle after req_valid rises.
- A transfer every cycle is sustained while busy, req_valid and res_ready are all high.
- Release edge: the last transfer occurs in cycle c, and gnt=0 and busy=0 from cycle c+1.
  - Exactly one IDLE cycle (c+1) follows.
  - The next grant is visible at c+2, giving one dead cycle per burst handoff.
- forced_release is high in cycle c+1 only.
- req_ready and res_valid are combinational from registered grant and inputs. There is no combinational path from req_valid to gnt.

## Test plan
- Reset, then req_valid=4'b1111 held, each requester sends 2-beat bursts with res_ready=1 → grant order 0,1,2,3,0.
  - Each grant carries exactly 2 transfers.
  - busy low for exactly 1 cycle between grants.
- Only requester 2 is valid with a 3-beat burst, and res_ready toggles 1,0,1,0,1 → 3 transfers occur only in the res_ready=1 cycles.
  - gnt=4'b0100 throughout; released after the 3rd transfer.
  - req_ready[0,1,3]=0 throughout.
- Requester 1 never asserts req_last, MAX_BURST=8 → release after exactly 8 transfers.
  - forced_release pulses once the cycle after the release.
  - ptr moves to 2, so a simultaneously waiting requester 0 loses to a waiting requester 3.
- The 8th beat also carries req_last=1 → release at the 8th transfer and forced_release stays 0.
- Granted requester 3 drops req_valid for 5 cycles mid-burst while requester 0 is valid → gnt stays 4'b1000 and res_valid=0 for those 5 cycles.
  - The burst resumes; requester 0 is granted only after requester 3's last beat.
- Assert reset for 1 cycle mid-burst on requester 2, with req_valid=4'b0110 still high → the next cycle shows gnt=0 and busy=0.
  - The cycle after that grants requester 1, since ptr was reset to 0.
